// File: rtl/rv_core_pkg.sv
// Shared core types: XLEN, the opcodes decode keys U_control on, the fetch
// buffer entry layout and the fetch control state.
package rv_core_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // DRAIN means responses for requests issued before a redirect are still due.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries; head is read straight from
// registered storage so decode never sees a combinational path from memory.
module fetch_fifo
  import rv_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         empty
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         full;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Flush only rewinds pointers; stale storage is hidden behind count == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full));

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues in-order imem requests under a 2-slot credit
// and presents buffered instructions to decode; redirects flush and drain.
module instr_fetch_stage
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [6:0]      opcode_out_d
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [1:0]      outstanding_q;
  logic [1:0]      outstanding_next;
  logic [1:0]      drop_cnt_q;
  logic [1:0]      drop_cnt_next;
  fetch_state_t    state;

  logic [XLEN-1:0] inflight_pc_q [2];
  logic            inflight_rd_q;
  logic            inflight_wr_q;

  logic            pop;
  logic            push;
  logic            req_fire;
  logic [2:0]      credit_used;
  logic [1:0]      fifo_count;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign state = (drop_cnt_q != 2'd0) ? DRAIN : FETCH;

  // Redirect wins: no pop, no push and no request in the redirect cycle.
  assign valid_d = !fifo_empty;
  assign pop     = valid_d && !stall_d && !redirect_valid;
  assign push    = imem_rsp_valid && (state == FETCH) && !redirect_valid;

  // Buffered plus in-flight entries, minus the one leaving this cycle, must fit in two slots.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q} - {2'b00, pop};
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < 3'd2);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push_entry.instr = imem_rsp_data;
  assign push_entry.pc    = inflight_pc_q[inflight_rd_q];

  always_comb begin
    pc_next          = pc_q;
    outstanding_next = outstanding_q + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
    drop_cnt_next    = drop_cnt_q;
    if (redirect_valid) begin
      pc_next       = {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt_next = outstanding_q - {1'b0, imem_rsp_valid};
    end else begin
      if (req_fire) begin
        pc_next = pc_q + XLEN'(4);
      end
      if (imem_rsp_valid && (state == DRAIN)) begin
        drop_cnt_next = drop_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
    end else begin
      pc_q          <= pc_next;
      outstanding_q <= outstanding_next;
      drop_cnt_q    <= drop_cnt_next;
    end
  end

  // Request PCs pair with responses by order; dropped responses still consume their slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_pc_q[0] <= '0;
      inflight_pc_q[1] <= '0;
      inflight_rd_q    <= 1'b0;
      inflight_wr_q    <= 1'b0;
    end else begin
      if (req_fire) begin
        inflight_pc_q[inflight_wr_q] <= pc_q;
        inflight_wr_q                <= ~inflight_wr_q;
      end
      if (imem_rsp_valid) begin
        inflight_rd_q <= ~inflight_rd_q;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  assign instr_d      = head.instr;
  assign pc_d         = head.pc;
  assign opcode_out_d = head.instr[6:0];

  rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != 2'd0));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: in-order memory model with programmable latency,
// decode-side scoreboard, hand sequences and a redirect vector table.
module tb_instr_fetch_stage;
  import rv_core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_d = 1'b0;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [6:0]  opcode_out_d;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .valid_d        (valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .opcode_out_d   (opcode_out_d)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_rsp_t;

  typedef struct {
    int          lat;
    int          pre;
    logic [31:0] rpc;
    logic [31:0] first_pc;
    logic [31:0] second_pc;
    int          req_next;
  } redir_vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  mem_rsp_t    mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = RESET_PC;

  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_instr;
  logic        obs_req_valid;
  logic [31:0] obs_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_006F;
    return {a[24:0], (a[2] ? OPC_AUIPC : OPC_LUI)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, observe after settling, score the cycle.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic stall,
                      input logic ready);
    logic [63:0] e;
    @(negedge clk);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    stall_d        = stall;
    imem_req_ready = ready;
    #1;
    obs_valid     = valid_d;
    obs_pc        = pc_d;
    obs_instr     = instr_d;
    obs_req_valid = imem_req_valid;
    obs_req_addr  = imem_req_addr;
    if (valid_d && !stall && !redir) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: actual pc_d=%h required no output (cycle %0d)", pc_d, cyc);
      end else begin
        e = exp_q.pop_front();
        check("decode_pc", pc_d, e[31:0]);
        check("decode_instr", instr_d, e[63:32]);
        check("decode_opcode", 32'(opcode_out_d), 32'(e[38:32]));
      end
    end
    if (redir) begin
      check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end else if (imem_req_valid && ready) begin
      check("req_addr", imem_req_addr, exp_pc);
      mem_q.push_back('{data: mem_word(imem_req_addr), due: cyc + mem_lat});
      exp_q.push_back({mem_word(imem_req_addr), imem_req_addr});
      exp_pc = exp_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #2;
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    stall_d        = 1'b0;
    mem_q.delete();
    exp_q.delete();
    exp_pc = RESET_PC;
    #1;
    check("rst_valid_d", 32'(valid_d), 32'd0);
    check("rst_instr_d", instr_d, 32'd0);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_opcode", 32'(opcode_out_d), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (cycles) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_to_valid(input string name);
    int k;
    k = 0;
    do begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      k++;
    end while (!obs_valid && k < 20);
    if (!obs_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual valid_d=0 required valid_d=1 within 20 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    redir_vec_t  vecs[4];
    logic        seq_valid[12];
    logic [31:0] seq_pc[12];
    logic        seq_req[12];
    logic        rdir;
    logic [31:0] rpc;

    vecs[0] = '{lat: 3, pre: 6, rpc: 32'h0000_0103, first_pc: 32'h0000_0100,
                second_pc: 32'h0000_0104, req_next: -1};
    vecs[1] = '{lat: 1, pre: 6, rpc: 32'hFFFF_FFFC, first_pc: 32'hFFFF_FFFC,
                second_pc: 32'h0000_0000, req_next: 1};
    vecs[2] = '{lat: 2, pre: 5, rpc: 32'h0000_0202, first_pc: 32'h0000_0200,
                second_pc: 32'h0000_0204, req_next: -1};
    vecs[3] = '{lat: 1, pre: 6, rpc: 32'h0000_0041, first_pc: 32'h0000_0040,
                second_pc: 32'h0000_0044, req_next: 1};

    // Latency-1 start-up with a 5-cycle stall over steps 4..8.
    for (int k = 0; k < 12; k++) begin
      seq_valid[k] = (k >= 2);
      seq_req[k]   = !(k >= 4 && k <= 8);
      seq_pc[k]    = (k <= 3) ? 32'((k - 2) * 4) : (k <= 9) ? 32'h8 : 32'((k - 7) * 4);
    end

    apply_reset(3);
    mem_lat = 1;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 32'h0, (k >= 4 && k <= 8), 1'b1);
      check("seq_valid_d", 32'(obs_valid), 32'(seq_valid[k]));
      check("seq_req_valid", 32'(obs_req_valid), 32'(seq_req[k]));
      if (seq_valid[k]) check("seq_pc_d", obs_pc, seq_pc[k]);
      if (k <= 2) check("seq_req_addr", obs_req_addr, 32'(k * 4));
      if (k == 2) check("seq_first_instr", obs_instr, 32'h0000_006F);
      if (k >= 4 && k <= 8) check("stall_hold_instr", obs_instr, mem_word(32'h8));
    end

    // Redirect table: flush, drop in-flight responses, resume at the aligned target.
    for (int i = 0; i < 4; i++) begin
      mem_lat = vecs[i].lat;
      repeat (vecs[i].pre) step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, vecs[i].rpc, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check("redir_valid_next", 32'(obs_valid), 32'd0);
      if (vecs[i].req_next >= 0) begin
        check("redir_req_next", 32'(obs_req_valid), 32'(vecs[i].req_next));
        check("redir_req_addr", obs_req_addr, vecs[i].first_pc);
      end
      run_to_valid("redir_first");
      check("redir_first_pc", obs_pc, vecs[i].first_pc);
      run_to_valid("redir_second");
      check("redir_second_pc", obs_pc, vecs[i].second_pc);
    end

    // Reset in the middle of a latency-3 stream, then restart from RESET_PC.
    mem_lat = 3;
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);
    apply_reset(2);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("restart_req_valid", 32'(obs_req_valid), 32'd1);
    check("restart_req_addr", obs_req_addr, RESET_PC);
    run_to_valid("restart");
    check("restart_pc", obs_pc, RESET_PC);

    // Random traffic: backpressure, stalls, occasional redirects, varying latency.
    for (int k = 0; k < 300; k++) begin
      if (k % 25 == 0) mem_lat = $urandom_range(1, 3);
      rdir = ($urandom_range(0, 15) == 0);
      rpc  = $urandom;
      step(rdir, rpc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
